// File: rtl/axil_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB bridge.
package axil_apb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // APB slave error maps straight onto the AXI response code.
  function automatic logic [1:0] resp_from_err(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_apb_resp_buf.sv
// Valid/ready response holder for one AXI response channel (B or R).
// OPT=0: a single output register; full whenever a response is waiting.
// OPT=1: output register plus one spare slot, so one more APB transfer can
//        finish while the master is stalling the current response.
module axil_apb_resp_buf #(
  parameter int W   = 2,
  parameter bit OPT = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_full
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         w_pop;

  assign w_pop   = r_out_valid && i_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

  if (OPT) begin : g_skid
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;
    logic         w_out_free;

    assign w_out_free = !r_out_valid || w_pop;
    // A pop this cycle frees the spare slot, so a new grant may refill it.
    assign o_full     = r_skid_valid && !w_pop;

    // Output register drains from the spare slot first, then takes new data.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_out_valid  <= 1'b0;
        r_out_data   <= '0;
        r_skid_valid <= 1'b0;
        r_skid_data  <= '0;
      end else if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_skid_valid <= i_push;
          if (i_push) r_skid_data <= i_data;
        end else begin
          r_out_valid <= i_push;
          if (i_push) r_out_data <= i_data;
        end
      end else if (i_push) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_data;
      end
    end
  end else begin : g_plain
    assign o_full = r_out_valid;

    // Plain register: set on push, cleared after the handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else if (i_push) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_data;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_to_apb_bridge.sv
// AXI4-Lite slave to APB master bridge; one APB transfer in flight at a time.
//
// state  | meaning
// IDLE   | no transfer; arbitrate and grant an eligible AXI request
// SETUP  | PSEL=1, PENABLE=0 with captured address/data
// ACCESS | PSEL=1, PENABLE=1, held until PREADY
module axil_to_apb_bridge
  import axil_apb_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH        = 32,
  parameter int C_AXI_DATA_WIDTH        = 32,
  parameter bit OPT_OUTGOING_SKIDBUFFER = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  output logic [1:0]                    S_AXI_BRESP,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_APB_PADDR,
  output logic [2:0]                    M_APB_PPROT,
  output logic                          M_APB_PSEL,
  output logic                          M_APB_PENABLE,
  output logic                          M_APB_PWRITE,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_APB_PWDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_APB_PWSTRB,
  input  logic                          M_APB_PREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_APB_PRDATA,
  input  logic                          M_APB_PSLVERR
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  apb_state_e      r_state;
  apb_state_e      w_next;
  logic            r_prefer_wr;
  logic            r_is_write;
  logic [AW-1:0]   r_addr;
  logic [2:0]      r_prot;
  logic [DW-1:0]   r_wdata;
  logic [SW-1:0]   r_wstrb;

  logic            w_b_full;
  logic            w_r_full;
  logic            w_wr_elig;
  logic            w_rd_elig;
  logic            w_grant_wr;
  logic            w_grant_rd;
  logic            w_xfer_done;
  logic [1:0]      w_resp;
  logic [DW+1:0]   w_r_out;

  // Requests are only eligible when their response path has room; nothing
  // is accepted while reset is asserted.
  assign w_wr_elig   = !rst_i && S_AXI_AWVALID && S_AXI_WVALID && !w_b_full;
  assign w_rd_elig   = !rst_i && S_AXI_ARVALID && !w_r_full;
  assign w_xfer_done = (r_state == ACCESS) && M_APB_PREADY;
  assign w_resp      = resp_from_err(M_APB_PSLVERR);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and grant decode; grants only happen in IDLE.
  always_comb begin
    w_next     = r_state;
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wr_elig && (!w_rd_elig || r_prefer_wr)) w_grant_wr = 1'b1;
        else if (w_rd_elig)                           w_grant_rd = 1'b1;
        if (w_grant_wr || w_grant_rd) w_next = SETUP;
      end
      SETUP:   w_next = ACCESS;
      ACCESS:  if (M_APB_PREADY) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the granted request and flip the arbitration pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prefer_wr <= 1'b0;
      r_is_write  <= 1'b0;
      r_addr      <= '0;
      r_prot      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else if (w_grant_wr) begin
      r_prefer_wr <= 1'b0;
      r_is_write  <= 1'b1;
      r_addr      <= S_AXI_AWADDR;
      r_prot      <= S_AXI_AWPROT;
      r_wdata     <= S_AXI_WDATA;
      r_wstrb     <= S_AXI_WSTRB;
    end else if (w_grant_rd) begin
      r_prefer_wr <= 1'b1;
      r_is_write  <= 1'b0;
      r_addr      <= S_AXI_ARADDR;
      r_prot      <= S_AXI_ARPROT;
      r_wstrb     <= '0;
    end
  end

  assign S_AXI_AWREADY = w_grant_wr;
  assign S_AXI_WREADY  = w_grant_wr;
  assign S_AXI_ARREADY = w_grant_rd;

  assign M_APB_PSEL    = (r_state != IDLE);
  assign M_APB_PENABLE = (r_state == ACCESS);
  assign M_APB_PWRITE  = r_is_write;
  assign M_APB_PADDR   = r_addr;
  assign M_APB_PPROT   = r_prot;
  assign M_APB_PWDATA  = r_wdata;
  assign M_APB_PWSTRB  = r_wstrb;

  axil_apb_resp_buf #(.W(2), .OPT(OPT_OUTGOING_SKIDBUFFER)) u_b_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_xfer_done && r_is_write),
    .i_data  (w_resp),
    .i_ready (S_AXI_BREADY),
    .o_valid (S_AXI_BVALID),
    .o_data  (S_AXI_BRESP),
    .o_full  (w_b_full)
  );

  axil_apb_resp_buf #(.W(DW + 2), .OPT(OPT_OUTGOING_SKIDBUFFER)) u_r_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_xfer_done && !r_is_write),
    .i_data  ({w_resp, M_APB_PRDATA}),
    .i_ready (S_AXI_RREADY),
    .o_valid (S_AXI_RVALID),
    .o_data  (w_r_out),
    .o_full  (w_r_full)
  );

  assign S_AXI_RRESP = w_r_out[DW+1:DW];
  assign S_AXI_RDATA = w_r_out[DW-1:0];

endmodule

// File: tb/tb_axil_to_apb_bridge.sv
// Directed bench for axil_to_apb_bridge. Two instances share the stimulus:
// u_dut without the response skid buffer, u_dut_b with it.
module tb_axil_to_apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, wvalid, bready, arvalid, rready, pready, pslverr;
  logic [31:0] awaddr, wdata, araddr, prdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  logic        awready, wready, bvalid, arready, rvalid, psel, penable, pwrite;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pwstrb;

  logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b, psel_b, penable_b, pwrite_b;
  logic [1:0]  bresp_b, rresp_b;
  logic [31:0] rdata_b, paddr_b, pwdata_b;
  logic [2:0]  pprot_b;
  logic [3:0]  pwstrb_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axil_to_apb_bridge #(.C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32), .OPT_OUTGOING_SKIDBUFFER(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .M_APB_PADDR(paddr), .M_APB_PPROT(pprot), .M_APB_PSEL(psel), .M_APB_PENABLE(penable),
    .M_APB_PWRITE(pwrite), .M_APB_PWDATA(pwdata), .M_APB_PWSTRB(pwstrb),
    .M_APB_PREADY(pready), .M_APB_PRDATA(prdata), .M_APB_PSLVERR(pslverr)
  );

  axil_to_apb_bridge #(.C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32), .OPT_OUTGOING_SKIDBUFFER(1'b1)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_b), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_b), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid_b), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp_b),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_b), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_RVALID(rvalid_b), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata_b), .S_AXI_RRESP(rresp_b),
    .M_APB_PADDR(paddr_b), .M_APB_PPROT(pprot_b), .M_APB_PSEL(psel_b), .M_APB_PENABLE(penable_b),
    .M_APB_PWRITE(pwrite_b), .M_APB_PWDATA(pwdata_b), .M_APB_PWSTRB(pwstrb_b),
    .M_APB_PREADY(pready), .M_APB_PRDATA(prdata), .M_APB_PSLVERR(pslverr)
  );

  task automatic idle_inputs();
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    pready = 0; pslverr = 0; prdata = '0;
    awaddr = '0; wdata = '0; wstrb = '0; awprot = '0; araddr = '0; arprot = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Drives one AXI transaction on u_dut and plays the APB slave. Only
  // observes; the calling test does the comparisons.
  task automatic do_xfer(
    input  logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
    input  logic [2:0] prot, input int waits, input logic err, input logic [31:0] rd_val, input int hold,
    output logic granted, output logic setup_ok, output logic [31:0] o_paddr, output logic o_pwrite,
    output logic [31:0] o_pwdata, output logic [3:0] o_pwstrb, output logic [2:0] o_pprot,
    output int acc_cycles, output logic stable, output int lat, output logic got_valid,
    output logic psel_resp, output logic [1:0] o_resp, output logic [31:0] o_rdata,
    output logic held_ok, output logic cleared);
    granted = 0; setup_ok = 0; stable = 1; acc_cycles = 0; lat = 0; got_valid = 0;
    psel_resp = 1; o_resp = 2'bxx; o_rdata = 'x; held_ok = 1; cleared = 0;
    o_paddr = 'x; o_pwrite = 1'bx; o_pwdata = 'x; o_pwstrb = 'x; o_pprot = 'x;
    @(negedge clk);
    if (wr) begin
      awvalid = 1; wvalid = 1; awaddr = addr; wdata = data; wstrb = strb; awprot = prot;
    end else begin
      arvalid = 1; araddr = addr; arprot = prot;
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      granted = wr ? (awready && wready) : arready;
      if (granted) break;
      @(negedge clk);
    end
    if (!granted) begin
      if (wr) begin awvalid = 0; wvalid = 0; end else arvalid = 0;
      return;
    end
    @(negedge clk);
    if (wr) begin awvalid = 0; wvalid = 0; end else arvalid = 0;
    lat = 1;
    setup_ok = psel && !penable;
    o_paddr = paddr; o_pwrite = pwrite; o_pwdata = pwdata; o_pwstrb = pwstrb; o_pprot = pprot;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      acc_cycles++;
      if (!(psel && penable) || paddr !== o_paddr || pwrite !== o_pwrite || pwdata !== o_pwdata ||
          pwstrb !== o_pwstrb || pprot !== o_pprot) stable = 0;
      if (k == waits) begin
        pready = 1; pslverr = err; prdata = rd_val;
        break;
      end
      pready = 0; pslverr = 0; prdata = 32'hBAD0_0000 | k;
    end
    @(negedge clk);
    lat++;
    pready = 0; pslverr = 0; prdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      got_valid = wr ? bvalid : rvalid;
      if (got_valid) break;
      @(negedge clk);
      lat++;
    end
    if (!got_valid) return;
    psel_resp = psel;
    o_resp  = wr ? bresp : rresp;
    o_rdata = rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      prdata = 32'h5555_0000 | h;
      if (!(wr ? bvalid : rvalid) || (wr ? bresp : rresp) !== o_resp || (!wr && rdata !== o_rdata)) held_ok = 0;
    end
    if (wr) bready = 1; else rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    cleared = !(wr ? bvalid : rvalid);
  endtask

  logic        g, su, pw, st, gv, pr, ho, cl;
  logic [31:0] pa, pd, rd;
  logic [3:0]  ps;
  logic [2:0]  pp;
  logic [1:0]  rs;
  int          ac, lt;

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    awvalid = 1; wvalid = 1; arvalid = 1;
    repeat (2) @(negedge clk);
    n_checks++; if (psel !== 0)    begin n_fail++; $display("FAIL reset_psel: got %b expected 0", psel); end
    n_checks++; if (penable !== 0) begin n_fail++; $display("FAIL reset_penable: got %b expected 0", penable); end
    n_checks++; if (bvalid !== 0 || rvalid !== 0) begin n_fail++; $display("FAIL reset_valids: got b=%b r=%b expected 0", bvalid, rvalid); end
    n_checks++; if (awready !== 0 || arready !== 0 || wready !== 0) begin n_fail++; $display("FAIL reset_readys: got aw=%b w=%b ar=%b expected 0", awready, wready, arready); end
    n_checks++; if (paddr !== 0 || pwstrb !== 0 || pwrite !== 0) begin n_fail++; $display("FAIL reset_apb: got paddr=%h pwstrb=%h pwrite=%b expected 0", paddr, pwstrb, pwrite); end
    idle_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_single_write();
    do_xfer(1, 32'h0004_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 32'h0, 0,
            g, su, pa, pw, pd, ps, pp, ac, st, lt, gv, pr, rs, rd, ho, cl);
    n_checks++; if (g !== 1)  begin n_fail++; $display("FAIL wr_granted: got %b expected 1", g); end
    n_checks++; if (su !== 1) begin n_fail++; $display("FAIL wr_setup: got %b expected 1", su); end
    n_checks++; if (pa !== 32'h0004_0010) begin n_fail++; $display("FAIL wr_paddr: got %h expected 00040010", pa); end
    n_checks++; if (pw !== 1) begin n_fail++; $display("FAIL wr_pwrite: got %b expected 1", pw); end
    n_checks++; if (pd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_pwdata: got %h expected deadbeef", pd); end
    n_checks++; if (ps !== 4'hF) begin n_fail++; $display("FAIL wr_pwstrb: got %h expected f", ps); end
    n_checks++; if (ac !== 1 || st !== 1) begin n_fail++; $display("FAIL wr_access: got cycles=%0d stable=%b expected 1/1", ac, st); end
    n_checks++; if (lt !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", lt); end
    n_checks++; if (gv !== 1 || rs !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got valid=%b resp=%b expected 1/00", gv, rs); end
    n_checks++; if (pr !== 0) begin n_fail++; $display("FAIL wr_psel_idle: got %b expected 0", pr); end
    n_checks++; if (cl !== 1) begin n_fail++; $display("FAIL wr_bvalid_clear: got %b expected 1", cl); end
  endtask

  task automatic test_single_read();
    do_xfer(0, 32'h0004_1000, 32'h0, 4'h0, 3'b101, 3, 0, 32'h1234_5678, 2,
            g, su, pa, pw, pd, ps, pp, ac, st, lt, gv, pr, rs, rd, ho, cl);
    n_checks++; if (g !== 1 || su !== 1) begin n_fail++; $display("FAIL rd_grant_setup: got %b/%b expected 1/1", g, su); end
    n_checks++; if (pa !== 32'h0004_1000) begin n_fail++; $display("FAIL rd_paddr: got %h expected 00041000", pa); end
    n_checks++; if (pw !== 0 || ps !== 4'h0) begin n_fail++; $display("FAIL rd_pwrite_pwstrb: got %b/%h expected 0/0", pw, ps); end
    n_checks++; if (pp !== 3'b101) begin n_fail++; $display("FAIL rd_pprot: got %b expected 101", pp); end
    n_checks++; if (ac !== 4) begin n_fail++; $display("FAIL rd_access_cycles: got %0d expected 4", ac); end
    n_checks++; if (st !== 1) begin n_fail++; $display("FAIL rd_apb_stable: got %b expected 1", st); end
    n_checks++; if (lt !== 6) begin n_fail++; $display("FAIL rd_latency: got %0d expected 6", lt); end
    n_checks++; if (gv !== 1 || rd !== 32'h1234_5678 || rs !== 2'b00) begin n_fail++; $display("FAIL rd_rdata: got v=%b %h/%b expected 1 12345678/00", gv, rd, rs); end
    n_checks++; if (ho !== 1) begin n_fail++; $display("FAIL rd_rdata_held: got %b expected 1", ho); end
    n_checks++; if (cl !== 1) begin n_fail++; $display("FAIL rd_rvalid_clear: got %b expected 1", cl); end
  endtask

  task automatic test_error();
    do_xfer(1, 32'h0004_0020, 32'h0000_00FF, 4'h1, 3'b010, 1, 1, 32'h0, 0,
            g, su, pa, pw, pd, ps, pp, ac, st, lt, gv, pr, rs, rd, ho, cl);
    n_checks++; if (gv !== 1 || rs !== 2'b10) begin n_fail++; $display("FAIL err_bresp: got v=%b %b expected 1/10", gv, rs); end
    n_checks++; if (pp !== 3'b010) begin n_fail++; $display("FAIL err_wr_pprot: got %b expected 010", pp); end
    do_xfer(0, 32'h0004_2004, 32'h0, 4'h0, 3'b000, 0, 1, 32'hCAFE_0001, 0,
            g, su, pa, pw, pd, ps, pp, ac, st, lt, gv, pr, rs, rd, ho, cl);
    n_checks++; if (gv !== 1 || rs !== 2'b10) begin n_fail++; $display("FAIL err_rresp: got v=%b %b expected 1/10", gv, rs); end
    n_checks++; if (rd !== 32'hCAFE_0001) begin n_fail++; $display("FAIL err_rdata: got %h expected cafe0001", rd); end
  endtask

  task automatic test_unaligned_zero_strb();
    do_xfer(1, 32'h0004_0013, 32'h0102_0304, 4'h0, 3'b000, 0, 0, 32'h0, 0,
            g, su, pa, pw, pd, ps, pp, ac, st, lt, gv, pr, rs, rd, ho, cl);
    n_checks++; if (g !== 1 || su !== 1) begin n_fail++; $display("FAIL zs_issued: got %b/%b expected 1/1", g, su); end
    n_checks++; if (pa !== 32'h0004_0013) begin n_fail++; $display("FAIL zs_paddr: got %h expected 00040013", pa); end
    n_checks++; if (ps !== 4'h0 || pd !== 32'h0102_0304) begin n_fail++; $display("FAIL zs_pwstrb_pwdata: got %h/%h expected 0/01020304", ps, pd); end
    n_checks++; if (gv !== 1 || rs !== 2'b00) begin n_fail++; $display("FAIL zs_bresp: got v=%b %b expected 1/00", gv, rs); end
  endtask

  task automatic test_aw_only();
    logic seen_ready, seen_psel;
    seen_ready = 0; seen_psel = 0;
    @(negedge clk);
    awvalid = 1; wvalid = 0; awaddr = 32'h0004_0100; wdata = 32'h0; wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (awready || wready) seen_ready = 1;
      @(negedge clk);
      if (psel) seen_psel = 1;
    end
    n_checks++; if (seen_ready !== 0) begin n_fail++; $display("FAIL awonly_ready: got %b expected 0", seen_ready); end
    n_checks++; if (seen_psel !== 0) begin n_fail++; $display("FAIL awonly_psel: got %b expected 0", seen_psel); end
    do_xfer(0, 32'h0004_3000, 32'h0, 4'h0, 3'b000, 0, 0, 32'h0BAD_F00D, 0,
            g, su, pa, pw, pd, ps, pp, ac, st, lt, gv, pr, rs, rd, ho, cl);
    n_checks++; if (g !== 1 || pw !== 0) begin n_fail++; $display("FAIL awonly_read_granted: got %b pwrite=%b expected 1/0", g, pw); end
    n_checks++; if (gv !== 1 || rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL awonly_read_data: got v=%b %h expected 1 0badf00d", gv, rd); end
    awvalid = 0;
  endtask

  task automatic test_arbitration();
    logic        order_w[4];
    logic [31:0] order_a[4];
    int          n_seen;
    logic        prev;
    do_reset();
    @(negedge clk);
    awvalid = 1; wvalid = 1; awaddr = 32'h0000_0200; wdata = 32'hA5A5_A5A5; wstrb = 4'h3;
    arvalid = 1; araddr = 32'h0000_0100;
    bready = 1; rready = 1; pready = 1;
    #1;
    n_checks++; if (arready !== 1 || awready !== 0) begin n_fail++; $display("FAIL arb_first_grant: got ar=%b aw=%b expected 1/0", arready, awready); end
    n_seen = 0; prev = 0;
    for (int c = 0; c < 40 && n_seen < 4; c++) begin
      @(negedge clk);
      if (psel && !prev) begin
        order_w[n_seen] = pwrite;
        order_a[n_seen] = paddr;
        n_seen++;
      end
      prev = psel;
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    n_checks++; if (n_seen !== 4) begin n_fail++; $display("FAIL arb_count: got %0d transfers expected 4", n_seen); end
    for (int i = 0; i < n_seen; i++) begin
      n_checks++;
      if (order_w[i] !== i[0] || order_a[i] !== (i[0] ? 32'h0000_0200 : 32'h0000_0100)) begin
        n_fail++;
        $display("FAIL arb_order[%0d]: got pwrite=%b paddr=%h expected %b", i, order_w[i], order_a[i], i[0]);
      end
    end
    repeat (6) @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int  cnt0, cnt1, drop0, drop1, nb0, nb1;
    logic prev0, prev1;
    do_reset();
    @(negedge clk);
    pready = 1; bready = 0;
    awvalid = 1; wvalid = 1; awaddr = 32'h0000_0300; wdata = 32'h1111_1111; wstrb = 4'hF;
    #1;
    n_checks++; if (awready !== 1 || awready_b !== 1) begin n_fail++; $display("FAIL bp_first_grant: got %b/%b expected 1/1", awready, awready_b); end
    cnt0 = 0; cnt1 = 0; drop0 = 0; drop1 = 0; prev0 = 0; prev1 = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (psel && !prev0) cnt0++;
      if (psel_b && !prev1) cnt1++;
      prev0 = psel; prev1 = psel_b;
      if (c >= 3 && !bvalid) drop0++;
      if (c >= 3 && !bvalid_b) drop1++;
    end
    n_checks++; if (cnt0 !== 1) begin n_fail++; $display("FAIL bp_opt0_transfers: got %0d expected 1", cnt0); end
    n_checks++; if (cnt1 !== 2) begin n_fail++; $display("FAIL bp_opt1_transfers: got %0d expected 2", cnt1); end
    n_checks++; if (drop0 !== 0) begin n_fail++; $display("FAIL bp_opt0_bvalid_held: got %0d low cycles expected 0", drop0); end
    n_checks++; if (drop1 !== 0) begin n_fail++; $display("FAIL bp_opt1_bvalid_held: got %0d low cycles expected 0", drop1); end
    @(negedge clk);
    awvalid = 0; wvalid = 0; bready = 1;
    nb0 = 0; nb1 = 0;
    for (int i = 0; i < 4; i++) begin
      if (bvalid) nb0++;
      if (bvalid_b) nb1++;
      @(negedge clk);
    end
    n_checks++; if (nb0 !== 1) begin n_fail++; $display("FAIL bp_opt0_b_count: got %0d expected 1", nb0); end
    n_checks++; if (nb1 !== 2) begin n_fail++; $display("FAIL bp_opt1_b_count: got %0d expected 2", nb1); end
    awvalid = 1; wvalid = 1;
    #1;
    n_checks++; if (awready !== 1) begin n_fail++; $display("FAIL bp_opt0_regrant: got %b expected 1", awready); end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    repeat (5) @(negedge clk);
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic ok, bad;
    @(negedge clk);
    pready = 1; rready = 0;
    arvalid = 1; araddr = 32'h0000_0400;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin #1; ok = arready; if (!ok) @(negedge clk); end
    @(negedge clk);
    arvalid = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (ok !== 1 || rvalid !== 1) begin n_fail++; $display("FAIL rst_mid_read_pending: got grant=%b rvalid=%b expected 1/1", ok, rvalid); end
    pready = 0;
    awvalid = 1; wvalid = 1; awaddr = 32'h0000_0500; wdata = 32'h7777_7777; wstrb = 4'hF;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin #1; ok = awready; if (!ok) @(negedge clk); end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    n_checks++; if (ok !== 1 || psel !== 1 || penable !== 1) begin n_fail++; $display("FAIL rst_mid_in_access: got grant=%b psel=%b penable=%b expected 1/1/1", ok, psel, penable); end
    rst = 1;
    #1;
    n_checks++; if (psel !== 0 || penable !== 0) begin n_fail++; $display("FAIL rst_mid_apb_drop: got psel=%b penable=%b expected 0/0", psel, penable); end
    n_checks++; if (bvalid !== 0 || rvalid !== 0) begin n_fail++; $display("FAIL rst_mid_valids: got b=%b r=%b expected 0/0", bvalid, rvalid); end
    @(negedge clk);
    rst = 0; pready = 1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (psel || bvalid || rvalid) bad = 1;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_no_response: got activity=%b expected 0", bad); end
    pready = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_single_read();
    test_error();
    test_unaligned_zero_strb();
    test_aw_only();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_to_apb_bridge.md
Name: axil_to_apb_bridge

Overview:
- Single-master protocol bridge: AXI4-Lite slave on one side, AMBA APB (v4, with PSTRB/PPROT) master on the other.
- Sits between the core's AXI-Lite interconnect and the APB peripheral subsystem (timers, RTC).
- Serialises reads and writes into one APB transfer at a time.
- Returns the APB PSLVERR as an AXI SLVERR response.

Parameters:
- C_AXI_ADDR_WIDTH, 32: AXI and APB address width.
- C_AXI_DATA_WIDTH, 32: AXI and APB data width; must be 32 or 64.
- OPT_OUTGOING_SKIDBUFFER, 0: 1 = one-deep response buffer so a new APB transfer may start while the previous B/R response is stalled; 0 = no new transfer until the response is accepted.

Ports:
- clk_i  in  1  clock; APB PCLK equals this clock.
- rst_i  in  1  asynchronous active-high reset.
- S_AXI_AWVALID/AWREADY  in/out  1/1  write address handshake.
- S_AXI_AWADDR  in  AW  write address.
- S_AXI_AWPROT  in  3  write protection.
- S_AXI_WVALID/WREADY  in/out  1/1  write data handshake.
- S_AXI_WDATA  in  DW  write data.
- S_AXI_WSTRB  in  DW/8  byte strobes.
- S_AXI_BVALID/BREADY  out/in  1/1  write response handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_ARVALID/ARREADY  in/out  1/1  read address handshake.
- S_AXI_ARADDR  in  AW  read address.
- S_AXI_ARPROT  in  3  read protection.
- S_AXI_RVALID/RREADY  out/in  1/1  read data handshake.
- S_AXI_RDATA  out  DW  read data.
- S_AXI_RRESP  out  2  read response.
- M_APB_PADDR  out  AW  APB address.
- M_APB_PPROT  out  3  APB protection.
- M_APB_PSEL  out  1  select.
- M_APB_PENABLE  out  1  enable.
- M_APB_PWRITE  out  1  write.
- M_APB_PWDATA  out  DW  write data.
- M_APB_PWSTRB  out  DW/8  write strobes.
- M_APB_PREADY  in  1  slave ready.
- M_APB_PRDATA  in  DW  read data.
- M_APB_PSLVERR  in  1  slave error.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, arbitration pointer set to "read first". Reset asserted mid-transfer aborts it immediately: PSEL/PENABLE drop and no AXI response is issued.
- FSM states: IDLE -> SETUP -> ACCESS -> IDLE.
- A write is eligible when AWVALID and WVALID are both high. AW and W are accepted together in the same cycle; neither is accepted alone.
- A read is eligible when ARVALID is high.
- Response gating:
  - OPT=0: a write is grantable only while BVALID=0, a read only while RVALID=0.
  - OPT=1: grantable while the corresponding one-deep buffer is not full.
- Arbitration: if both are eligible, alternate between them, starting with read after reset. A single eligible request is granted immediately.
- Ready signals: AWREADY/WREADY/ARREADY are combinational. They are high only in IDLE, for the granted direction, in the grant cycle.
- Grant cycle N: capture address, PROT, data and strobes into registers; go to SETUP.
- Cycle N+1 (SETUP): PSEL=1, PENABLE=0.
  - PADDR = captured address, unmodified.
  - PWRITE = direction.
  - PWDATA/PWSTRB = captured values on writes; PWSTRB=0 on reads.
  - PPROT = captured AxPROT.
- Cycle N+2 onward (ACCESS): PSEL=1, PENABLE=1, held with all APB outputs stable until PREADY=1.
- On PREADY=1:
  - Capture PRDATA (reads only) and PSLVERR.
  - Next cycle: PSEL=0, PENABLE=0, state IDLE; BVALID or RVALID=1.
  - Minimum AXI-handshake-to-response latency is 3 cycles.
- RESP = 2'b10 (SLVERR) if PSLVERR else 2'b00 (OKAY). RDATA is held stable while RVALID=1.
- BVALID/RVALID stay high until BREADY/RREADY; they clear in the cycle after the handshake.
- PSEL may re-assert in the cycle directly after IDLE is re-entered. No back-to-back without IDLE: there is at least one cycle with PSEL=0 between transfers.
- Boundaries:
  - AWVALID without WVALID: no acceptance, and reads stay serviceable.
  - Simultaneous RREADY clear and new grant with OPT=1: the buffer frees and refills in the same cycle.
  - Unaligned addresses pass through unchanged.
  - Zero WSTRB writes are still issued.

Decomposition:
- Shared package axil_apb_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, FSM state enum (IDLE, SETUP, ACCESS).
- One natural sub-module: axil_apb_resp_buf, the one-deep valid/ready response register used for the B and R channels. It is instantiated twice, bypassed to a plain register when OPT=0.

Test Plan:
- Single write: AW=0x0004_0010, W=0xDEADBEEF, STRB=0xF, PREADY high in ACCESS -> PSEL in cycle N+1, PENABLE in N+2, PWRITE=1, PWSTRB=0xF; BVALID at N+3, BRESP=00.
- Single read with 3 wait states: AR=0x0004_1000, PRDATA=0x1234_5678 -> ACCESS held 4 cycles with stable APB outputs; RVALID with RDATA=0x12345678, RRESP=00.
- Error: PSLVERR=1 on a write and on a read -> BRESP=10, RRESP=10.
- Arbitration: AW+W and AR asserted together, held valid for two transfers -> read first, then write (then alternating).
- Backpressure: BREADY=0 for 5 cycles with a second write pending -> OPT=0: no second APB transfer until B is accepted; OPT=1: second transfer completes and BVALID stays high throughout.
- Async reset asserted while in ACCESS -> PSEL, PENABLE, BVALID, RVALID all 0 immediately; no response after release.
